// File: rtl/run_ctrl.sv
// run_ctrl: run sequencer and the single dmem port arbiter for the core.
// Each run is: host preload (LOAD) -> core execution (RUN) -> halt (FINISH),
// with host readback available in IDLE and FINISH.
// Ports:
//   clk, reset (async, active-low)
//   start                         begin a run (IDLE/FINISH only)
//   ld_valid/ld_ready/ld_addr/ld_data/ld_last   host preload stream
//   rd_req/rd_addr -> rd_data/rd_valid          host readback, 1-cycle latency
//   core_clr/core_run/core_done                 core control and halt
//   core_we/core_addr/core_di/core_dout         core side of dmem
//   dm_we/dm_addr/dm_di/dm_dout                 the dmem port
//   busy/done/timeout/cycles                    run status
module run_ctrl #(
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 8,
  parameter int unsigned CW      = 16,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          core_clr,
  output logic          core_run,
  input  logic          core_done,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_di,
  output logic [DW-1:0] core_dout,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_di,
  input  logic [DW-1:0] dm_dout,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycles
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_FINISH} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cycles_nxt, cycles_inc;
  logic          timeout_nxt;
  logic          rd_ok;
  logic          done_hit, to_hit;

  assign core_dout = dm_dout;

  // Saturating run-cycle count; the first RUN cycle is the one with cycles==0,
  // where PC=0 aliases the halt condition and core_done must be ignored.
  assign cycles_inc = (cycles == {CW{1'b1}}) ? cycles : cycles + CW'(1);
  assign done_hit   = core_done && (cycles != '0);
  assign to_hit     = (cycles_inc == CW'(TIMEOUT));

  // Next-state, status updates and state-decoded dmem mux / control outputs
  always_comb begin
    state_nxt   = state;
    cycles_nxt  = cycles;
    timeout_nxt = timeout;
    ld_ready    = 1'b0;
    core_clr    = 1'b1;
    core_run    = 1'b0;
    dm_we       = 1'b0;
    dm_addr     = '0;
    dm_di       = '0;
    busy        = 1'b0;
    done        = 1'b0;
    rd_ok       = 1'b0;
    case (state)
      S_IDLE: begin
        rd_ok = rd_req;
        if (rd_req) dm_addr = rd_addr;
        if (start) begin
          state_nxt   = S_LOAD;
          cycles_nxt  = '0;
          timeout_nxt = 1'b0;
        end
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        busy     = 1'b1;
        dm_we    = ld_valid;
        dm_addr  = ld_addr;
        dm_di    = ld_data;
        if (ld_valid && ld_last) state_nxt = S_RUN;
      end
      S_RUN: begin
        core_run   = 1'b1;
        core_clr   = 1'b0;
        busy       = 1'b1;
        dm_we      = core_we;
        dm_addr    = core_addr;
        dm_di      = core_di;
        cycles_nxt = cycles_inc;
        // A real halt takes priority over a coincident timeout.
        if (done_hit) begin
          state_nxt   = S_FINISH;
          timeout_nxt = 1'b0;
        end else if (to_hit) begin
          state_nxt   = S_FINISH;
          timeout_nxt = 1'b1;
        end
      end
      S_FINISH: begin
        done  = 1'b1;
        rd_ok = rd_req;
        if (rd_req) dm_addr = rd_addr;
        if (start) begin
          state_nxt   = S_LOAD;
          cycles_nxt  = '0;
          timeout_nxt = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, status and readback registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cycles   <= '0;
      timeout  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      state    <= state_nxt;
      cycles   <= cycles_nxt;
      timeout  <= timeout_nxt;
      rd_valid <= rd_ok;
      if (rd_ok) rd_data <= dm_dout;
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed + randomized bench for run_ctrl with a behavioural
// dmem and a reference model of memory contents and run outcome.
module tb_run_ctrl;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;
  localparam int unsigned TO = 24;

  logic          clk = 1'b0;
  logic          reset, start, ld_valid, ld_last, rd_req, core_done, core_we;
  logic [AW-1:0] ld_addr, rd_addr, core_addr;
  logic [DW-1:0] ld_data, core_di;
  logic          ld_ready, rd_valid, core_clr, core_run, dm_we, busy, done, timeout;
  logic [DW-1:0] rd_data, core_dout, dm_di, dm_dout;
  logic [AW-1:0] dm_addr;
  logic [CW-1:0] cycles;

  run_ctrl #(.AW(AW), .DW(DW), .CW(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .core_clr(core_clr), .core_run(core_run), .core_done(core_done),
    .core_we(core_we), .core_addr(core_addr), .core_di(core_di), .core_dout(core_dout),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_di(dm_di), .dm_dout(dm_dout),
    .busy(busy), .done(done), .timeout(timeout), .cycles(cycles)
  );

  always #5 clk = ~clk;

  // Behavioural dmem on the controller's port
  logic [DW-1:0] mem [256] = '{default: 8'h00};
  always @(posedge clk) if (dm_we) mem[dm_addr] <= dm_di;
  assign dm_dout = mem[dm_addr];

  // Number of clock edges on which dmem was written
  int we_cnt = 0;
  always @(posedge clk) if (dm_we) we_cnt <= we_cnt + 1;

  // Reference: expected memory contents
  logic [DW-1:0] ref_mem [256] = '{default: 8'h00};

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One host load word after 'gap' idle cycles; ends at the negedge after the transfer edge
  task automatic load_word(input logic [7:0] a, input logic [7:0] d, input logic last, input int gap);
    for (int g = 0; g < gap; g++) begin
      ld_valid = 1'b0;
      #1 check("ld_gap_we", 32'(dm_we), 32'd0);
      @(negedge clk);
    end
    ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_last = last;
    start = 1'($urandom_range(0, 1));
    #1 check("ld_we", 32'(dm_we), 32'd1);
    check("ld_addr", 32'(dm_addr), 32'(a));
    @(negedge clk);
    ref_mem[a] = d;
    ld_valid = 1'b0; ld_last = 1'b0; start = 1'b0;
  endtask

  task automatic rand_load();
    int n;
    n = int'($urandom_range(2, 5));
    for (int i = 0; i < n; i++)
      load_word(8'($urandom_range(0, 127)), 8'($urandom), (i == n - 1), int'($urandom_range(0, 2)));
  endtask

  // RUN phase; done_at = RUN cycle index that raises core_done (-1: never).
  // core_done is also raised on RUN cycle 0, which must be ignored.
  task automatic run_phase(input int done_at);
    int  exp_cycles;
    bit  exp_to, found;
    int  ended_at;
    exp_to     = !(done_at >= 1 && done_at < int'(TO));
    exp_cycles = exp_to ? int'(TO) : done_at + 1;
    found      = 1'b0;
    ended_at   = -1;
    check("run_core_run", 32'(core_run), 32'd1);
    check("run_core_clr", 32'(core_clr), 32'd0);
    for (int k = 0; k < int'(TO) + 4; k++) begin
      core_done = (k == 0) || (k == done_at);
      core_we   = 1'($urandom_range(0, 1));
      core_addr = 8'h80 | 8'($urandom_range(0, 127));
      core_di   = 8'($urandom);
      start     = 1'($urandom_range(0, 1));
      #1;
      if (k < exp_cycles) begin
        check("run_dm_we", 32'(dm_we), 32'(core_we));
        if (core_we) check("run_dm_addr", 32'(dm_addr), 32'(core_addr));
        if (core_we) ref_mem[core_addr] = core_di;
      end
      @(negedge clk);
      start = 1'b0; core_done = 1'b0; core_we = 1'b0;
      if (done === 1'b1) begin
        found = 1'b1; ended_at = k;
        break;
      end
    end
    check("run_ended", 32'(found), 32'd1);
    check("run_len", 32'(ended_at + 1), 32'(exp_cycles));
    check("cycles", 32'(cycles), 32'(exp_cycles));
    check("timeout", 32'(timeout), 32'(exp_to));
    check("fin_core_clr", 32'(core_clr), 32'd1);
    check("fin_core_run", 32'(core_run), 32'd0);
    check("fin_busy", 32'(busy), 32'd0);
    core_we = 1'b1;
    #1 check("fin_no_we", 32'(dm_we), 32'd0);
    core_we = 1'b0;
  endtask

  task automatic rd_check(input logic [7:0] a);
    rd_req = 1'b1; rd_addr = a;
    @(negedge clk);
    rd_req = 1'b0;
    check("rd_valid", 32'(rd_valid), 32'd1);
    check("rd_data", 32'(rd_data), 32'(ref_mem[a]));
  endtask

  task automatic begin_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("load_ready", 32'(ld_ready), 32'd1);
    check("load_busy", 32'(busy), 32'd1);
    check("load_cycles", 32'(cycles), 32'd0);
    check("load_timeout", 32'(timeout), 32'd0);
  endtask

  initial begin
    int w0;
    int runs [3] = '{-1, int'(TO) - 1, 0};
    runs[2] = int'($urandom_range(1, TO - 2));
    reset = 1'b0; start = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; rd_req = 1'b0;
    core_done = 1'b0; core_we = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
    core_addr = '0; core_di = '0;

    // Reset held with start asserted
    repeat (2) @(negedge clk);
    check("rst_core_clr", 32'(core_clr), 32'd1);
    check("rst_core_run", 32'(core_run), 32'd0);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cycles", 32'(cycles), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rel_ld_ready", 32'(ld_ready), 32'd1);

    // Readback ignored in LOAD
    rd_req = 1'b1; rd_addr = 8'h00;
    @(negedge clk);
    rd_req = 1'b0;
    check("ld_rd_ignored", 32'(rd_valid), 32'd0);

    // Fixed preload with a 2-cycle valid gap
    w0 = we_cnt;
    load_word(8'h10, 8'hA5, 1'b0, 0);
    load_word(8'h11, 8'h5A, 1'b0, 2);
    load_word(8'h12, 8'hFF, 1'b1, 0);
    check("ld_we_cycles", 32'(we_cnt - w0), 32'd3);
    run_phase(20);

    rd_check(8'h11);
    rd_check(8'h10);
    rd_check(8'h12);
    rd_check(8'(8'h80 | 8'($urandom_range(0, 127))));
    @(negedge clk);
    check("rd_valid_idle", 32'(rd_valid), 32'd0);

    // Timeout, done on the last legal cycle, random halt point
    for (int s = 0; s < 3; s++) begin
      begin_run();
      rand_load();
      run_phase(runs[s]);
      rd_check(8'($urandom_range(0, 127)));
      rd_check(8'(8'h80 | 8'($urandom_range(0, 127))));
    end

    // Asynchronous reset in the middle of RUN
    begin_run();
    rand_load();
    repeat (3) @(negedge clk);
    core_we = 1'b1; core_addr = 8'hF0; core_di = 8'h33;
    #2 reset = 1'b0;
    #1;
    check("arst_core_run", 32'(core_run), 32'd0);
    check("arst_dm_we", 32'(dm_we), 32'd0);
    check("arst_core_clr", 32'(core_clr), 32'd1);
    check("arst_cycles", 32'(cycles), 32'd0);
    @(negedge clk);
    reset = 1'b1; core_we = 1'b0;
    @(negedge clk);
    check("arst_idle_busy", 32'(busy), 32'd0);
    check("arst_idle_done", 32'(done), 32'd0);
    begin_run();
    rand_load();
    run_phase(int'($urandom_range(1, TO + 3)));
    rd_check(8'h11);
    rd_check(8'(8'h80 | 8'($urandom_range(0, 127))));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
